// File: rtl/memory_pkg.sv
// Shared definitions for the pipelined memory block.
// Contents:
//   ST_INIT / ST_IDLE / ST_READ_WAIT   FSM state encodings
//   INIT_ZERO / INIT_ADDR              post-reset fill pattern selectors
//   lat_width()                        width of the read-latency counter
package memory_pkg;

  localparam logic [1:0] ST_INIT      = 2'd0;
  localparam logic [1:0] ST_IDLE      = 2'd1;
  localparam logic [1:0] ST_READ_WAIT = 2'd2;

  localparam int INIT_ZERO = 0;
  localparam int INIT_ADDR = 1;

  // The counter has to hold the value lat itself.
  function automatic int lat_width(input int lat);
    return $clog2(lat + 1);
  endfunction

endpackage

// File: rtl/memory_array.sv
// Plain synchronous single-port RAM with a registered read.
// Ports:
//   clock  rising-edge clock
//   we     write enable; wdata is stored at addr on the edge
//   addr   word address, shared by the read and write paths
//   wdata  write data
//   rdata  registered read data (contents of addr at the previous edge)
module memory_array #(
  parameter int ADDR_SIZE = 6,
  parameter int WORD_SIZE = 16
) (
  input  logic                 clock,
  input  logic                 we,
  input  logic [ADDR_SIZE-1:0] addr,
  input  logic [WORD_SIZE-1:0] wdata,
  output logic [WORD_SIZE-1:0] rdata
);

  logic [WORD_SIZE-1:0] mem [2**ADDR_SIZE];

  // Read-before-write: a write and a read of one address on the same edge
  // return the old word. The controller never depends on that case.
  always_ff @(posedge clock) begin
    if (we) mem[addr] <= wdata;
    rdata <= mem[addr];
  end

endmodule

// File: rtl/memory_pipelined.sv
// Clocked program/data store with an init sweep, configurable read latency
// and a ready/valid handshake.
// Ports:
//   clock, reset_n  clock (rising edge) and asynchronous active-low reset
//   read, write     request strobes, accepted on an edge where ready is high
//   address_in      request address
//   data_in         write data
//   ready           request is accepted at the next rising edge
//   out             read data; holds the last read value between reads
//   out_valid       one-cycle pulse while out carries fresh read data
//   busy            init sweep running or read in flight (inverse of ready)
//   conflict        one-cycle pulse after a read was accepted together with a write
//   state           current FSM state, exported for observation
//
// Handshake: a request is taken on a rising edge when ready=1 and
// (read || write). Read has priority and drops a simultaneous write. While a
// read is in flight, ready=0 and all requests are ignored. In the cycle where
// out_valid=1, ready is already 1, so a new request can be accepted then.
module memory_pipelined
  import memory_pkg::*;
#(
  parameter int ADDR_SIZE    = 6,
  parameter int WORD_SIZE    = 16,
  parameter int READ_LATENCY = 2,
  parameter int INIT_MODE    = 1
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 read,
  input  logic                 write,
  input  logic [ADDR_SIZE-1:0] address_in,
  input  logic [WORD_SIZE-1:0] data_in,
  output logic                 ready,
  output logic [WORD_SIZE-1:0] out,
  output logic                 out_valid,
  output logic                 busy,
  output logic                 conflict,
  output logic [1:0]           state
);

  localparam int LW = lat_width(READ_LATENCY);

  logic [ADDR_SIZE-1:0] init_cnt;
  logic [ADDR_SIZE-1:0] cap_addr;
  logic [LW-1:0]        lat_cnt;
  logic [WORD_SIZE-1:0] out_hold;
  logic [WORD_SIZE-1:0] rdata;
  logic [WORD_SIZE-1:0] init_word;
  logic [WORD_SIZE-1:0] mem_wdata;
  logic [ADDR_SIZE-1:0] mem_addr;
  logic                 mem_we;
  logic                 done;
  logic                 accept;

  // done marks the final latency cycle: data is presented and the block is
  // back to accepting requests in that same cycle.
  assign done      = (state == ST_READ_WAIT) && (lat_cnt == LW'(READ_LATENCY));
  assign ready     = (state == ST_IDLE) || done;
  assign busy      = !ready;
  assign out_valid = done;
  assign accept    = ready && (read || write);

  assign init_word = (INIT_MODE == INIT_ZERO) ? '0 : WORD_SIZE'(init_cnt);

  // While ready, the array is addressed by the incoming request so that a
  // read accepted on this edge lands in rdata at the same edge. While waiting,
  // the captured address keeps rdata current up to the done cycle.
  always_comb begin
    mem_addr  = address_in;
    mem_wdata = data_in;
    mem_we    = accept && write && !read;
    if (state == ST_INIT) begin
      mem_addr  = init_cnt;
      mem_wdata = init_word;
      mem_we    = 1'b1;
    end else if (!ready) begin
      mem_addr = cap_addr;
    end
  end

  // Fresh data goes straight from the array during the valid pulse and is
  // retained in out_hold afterwards, so out never needs an extra cycle.
  assign out = out_valid ? rdata : out_hold;

  memory_array #(
    .ADDR_SIZE(ADDR_SIZE),
    .WORD_SIZE(WORD_SIZE)
  ) u_array (
    .clock(clock),
    .we   (mem_we),
    .addr (mem_addr),
    .wdata(mem_wdata),
    .rdata(rdata)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ST_INIT;
      init_cnt <= '0;
      lat_cnt  <= '0;
      cap_addr <= '0;
      out_hold <= '0;
      conflict <= 1'b0;
    end else begin
      conflict <= accept && read && write;
      if (out_valid) out_hold <= rdata;
      case (state)
        ST_INIT: begin
          init_cnt <= init_cnt + ADDR_SIZE'(1);
          if (&init_cnt) state <= ST_IDLE;
        end
        ST_IDLE, ST_READ_WAIT: begin
          if (accept && read) begin
            state    <= ST_READ_WAIT;
            lat_cnt  <= LW'(1);
            cap_addr <= address_in;
          end else if ((state == ST_READ_WAIT) && !done) begin
            lat_cnt <= lat_cnt + LW'(1);
          end else begin
            state   <= ST_IDLE;
            lat_cnt <= '0;
          end
        end
        default: begin
          state    <= ST_INIT;
          init_cnt <= '0;
          lat_cnt  <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_memory_pipelined.sv
// Bench for memory_pipelined: a default instance (64 x 16, latency 2) and a
// small instance (16 x 8, latency 1). Read responses are checked by per-
// instance monitors against expected queues filled by the driver tasks.
module tb_memory_pipelined;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  // default instance
  logic        rst_n0 = 1'b0, read0 = 1'b0, write0 = 1'b0;
  logic [5:0]  addr0  = '0;
  logic [15:0] data0  = '0;
  logic        ready0, ov0, busy0, conf0;
  logic [15:0] out0;
  logic [1:0]  st0;

  // small instance
  logic        rst_n1 = 1'b0, read1 = 1'b0, write1 = 1'b0;
  logic [3:0]  addr1  = '0;
  logic [7:0]  data1  = '0;
  logic        ready1, ov1, busy1, conf1;
  logic [7:0]  out1;
  logic [1:0]  st1;

  memory_pipelined dut0 (
    .clock(clock), .reset_n(rst_n0), .read(read0), .write(write0),
    .address_in(addr0), .data_in(data0), .ready(ready0), .out(out0),
    .out_valid(ov0), .busy(busy0), .conflict(conf0), .state(st0)
  );

  memory_pipelined #(
    .ADDR_SIZE(4), .WORD_SIZE(8), .READ_LATENCY(1), .INIT_MODE(1)
  ) dut1 (
    .clock(clock), .reset_n(rst_n1), .read(read1), .write(write1),
    .address_in(addr1), .data_in(data1), .ready(ready1), .out(out1),
    .out_valid(ov1), .busy(busy1), .conflict(conf1), .state(st1)
  );

  // ---------------- scoreboard ----------------
  logic [15:0] exp0_q[$];
  logic [7:0]  exp1_q[$];
  int vcount0 = 0;
  int vcount1 = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clock) begin
    if (ov0 === 1'b1) begin
      vcount0++;
      if (exp0_q.size() == 0) begin
        total++; bad++;
        $display("FAIL dut0_unexpected_valid: got out=%0h expected no pulse", out0);
      end else begin
        check("dut0_read_data", {16'h0, out0}, {16'h0, exp0_q.pop_front()});
      end
    end
    if (ov1 === 1'b1) begin
      vcount1++;
      if (exp1_q.size() == 0) begin
        total++; bad++;
        $display("FAIL dut1_unexpected_valid: got out=%0h expected no pulse", out1);
      end else begin
        check("dut1_read_data", {24'h0, out1}, {24'h0, exp1_q.pop_front()});
      end
    end
  end

  // ---------------- drivers: default instance ----------------
  task automatic wait_rdy0();
    int n = 0;
    while (ready0 !== 1'b1 && n < 300) begin @(negedge clock); n++; end
    if (ready0 !== 1'b1) check("dut0_ready_timeout", {31'h0, ready0}, 32'h1);
  endtask

  task automatic count_init0(input int exp_cycles);
    int n = 0;
    while (ready0 !== 1'b1 && n < 300) begin @(negedge clock); n++; end
    check("dut0_init_cycles", n, exp_cycles);
  endtask

  task automatic wr0(input logic [5:0] a, input logic [15:0] d);
    wait_rdy0();
    write0 = 1'b1; addr0 = a; data0 = d;
    @(negedge clock);
    write0 = 1'b0;
  endtask

  task automatic rd0(input logic [5:0] a, input logic [15:0] e);
    wait_rdy0();
    read0 = 1'b1; addr0 = a;
    exp0_q.push_back(e);
    @(negedge clock);
    read0 = 1'b0;
  endtask

  // Read that also measures acceptance-to-valid latency and the ready shape.
  task automatic rd0_lat(input logic [5:0] a, input logic [15:0] e);
    int n;
    wait_rdy0();
    read0 = 1'b1; addr0 = a;
    exp0_q.push_back(e);
    @(negedge clock);
    read0 = 1'b0;
    n = 1;
    check("dut0_ready_low_in_wait", {31'h0, ready0}, 32'h0);
    while (ov0 !== 1'b1 && n < 20) begin @(negedge clock); n++; end
    check("dut0_read_latency", n, 2);
    check("dut0_ready_with_valid", {31'h0, ready0}, 32'h1);
  endtask

  // ---------------- drivers: small instance ----------------
  task automatic wait_rdy1();
    int n = 0;
    while (ready1 !== 1'b1 && n < 300) begin @(negedge clock); n++; end
    if (ready1 !== 1'b1) check("dut1_ready_timeout", {31'h0, ready1}, 32'h1);
  endtask

  task automatic wr1(input logic [3:0] a, input logic [7:0] d);
    wait_rdy1();
    write1 = 1'b1; addr1 = a; data1 = d;
    @(negedge clock);
    write1 = 1'b0;
  endtask

  task automatic rd1(input logic [3:0] a, input logic [7:0] e);
    wait_rdy1();
    read1 = 1'b1; addr1 = a;
    exp1_q.push_back(e);
    @(negedge clock);
    read1 = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;
    int vbefore;

    repeat (2) @(negedge clock);
    check("reset_ready", {31'h0, ready0}, 32'h0);
    check("reset_busy", {31'h0, busy0}, 32'h1);
    check("reset_out", {16'h0, out0}, 32'h0);
    check("reset_valid", {31'h0, ov0}, 32'h0);
    check("reset_conflict", {31'h0, conf0}, 32'h0);

    // init sweep length and fill pattern
    rst_n0 = 1'b1;
    count_init0(64);
    rd0(6'd0, 16'h0000);
    rd0(6'd5, 16'h0005);
    rd0(6'd63, 16'h003F);

    // write then read on the next cycle, with latency/ready checks
    wr0(6'd0, 16'h0450);
    rd0_lat(6'd0, 16'h0450);

    // back-to-back writes, then read them back
    wr0(6'd33, 16'hBEEF);
    wr0(6'd34, 16'h1357);
    rd0(6'd34, 16'h1357);
    rd0(6'd33, 16'hBEEF);

    // read and write together: read wins, write dropped
    wait_rdy0();
    read0 = 1'b1; write0 = 1'b1; addr0 = 6'd6; data0 = 16'hFFFF;
    exp0_q.push_back(16'h0006);
    @(negedge clock);
    read0 = 1'b0; write0 = 1'b0;
    check("conflict_pulse", {31'h0, conf0}, 32'h1);
    @(negedge clock);
    check("conflict_one_cycle", {31'h0, conf0}, 32'h0);
    rd0(6'd6, 16'h0006);

    // requests during READ_WAIT are ignored
    wait_rdy0();
    repeat (2) @(negedge clock);
    vbefore = vcount0;
    read0 = 1'b1; addr0 = 6'd10;
    exp0_q.push_back(16'h000A);
    @(negedge clock);
    addr0 = 6'd20; write0 = 1'b1; data0 = 16'h1234;
    @(negedge clock);
    read0 = 1'b0; write0 = 1'b0;
    repeat (4) @(negedge clock);
    check("single_valid_pulse", vcount0 - vbefore, 1);
    rd0(6'd20, 16'h0014);

    // reset in the middle of a read
    wait_rdy0();
    read0 = 1'b1; addr0 = 6'd7;
    @(negedge clock);
    read0 = 1'b0;
    rst_n0 = 1'b0;
    #1;
    check("midread_reset_out", {16'h0, out0}, 32'h0);
    check("midread_reset_ready", {31'h0, ready0}, 32'h0);
    check("midread_reset_busy", {31'h0, busy0}, 32'h1);
    @(negedge clock);
    rst_n0 = 1'b1;
    vbefore = vcount0;
    count_init0(64);
    check("midread_no_valid", vcount0 - vbefore, 0);
    check("midread_out_zero", {16'h0, out0}, 32'h0);
    rd0(6'd0, 16'h0000);
    rd0(6'd7, 16'h0007);

    // small instance: 16-word sweep, latency 1
    rst_n1 = 1'b1;
    n = 0;
    while (ready1 !== 1'b1 && n < 300) begin @(negedge clock); n++; end
    check("dut1_init_cycles", n, 16);
    for (int i = 0; i < 16; i++) rd1(4'(i), 8'(i));

    wait_rdy1();
    read1 = 1'b1; addr1 = 4'd5;
    exp1_q.push_back(8'h05);
    @(negedge clock);
    read1 = 1'b0;
    check("dut1_valid_next_cycle", {31'h0, ov1}, 32'h1);
    check("dut1_ready_with_valid", {31'h0, ready1}, 32'h1);

    wr1(4'd3, 8'hA5);
    wr1(4'd4, 8'h5A);
    rd1(4'd3, 8'hA5);
    rd1(4'd4, 8'h5A);

    // drain both scoreboards
    n = 0;
    while ((exp0_q.size() != 0 || exp1_q.size() != 0) && n < 50) begin
      @(negedge clock); n++;
    end
    check("dut0_queue_drained", exp0_q.size(), 0);
    check("dut1_queue_drained", exp1_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
